// File: rtl/zone_accum_pkg.sv
// Shared types and constants for the zone accumulator RAM.
package zone_accum_pkg;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // One extra bit on each channel adder catches the carry used to saturate.
  localparam int unsigned SatGuardBits = 1;

endpackage

// File: rtl/zone_accum_mem.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read, no reset.
module zone_accum_mem #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned WIDTH      = 60
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zone_accum_ram.sv
// Per-zone saturating colour accumulator with clear-on-read readout and a
// power-up clear sweep over the storage array.
module zone_accum_ram
  import zone_accum_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned CH_NUM     = 3,
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           acc_valid,
  input  logic [ADDR_WIDTH-1:0]          acc_addr,
  input  logic [CH_NUM*PIX_WIDTH-1:0]    acc_pix,
  output logic                           acc_ready,
  input  logic                           rd_req,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic                           rd_clear,
  output logic                           rd_valid,
  output logic [CH_NUM*DATA_WIDTH-1:0]   rd_data,
  output logic                           init_busy
);

  localparam int unsigned MemWidth = CH_NUM * DATA_WIDTH;
  localparam int unsigned SumWidth = DATA_WIDTH + SatGuardBits;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   sweep_q;
  logic                    wr_pend_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [MemWidth-1:0]     wr_data_q;
  logic                    clr_pend_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    rd_valid_q;
  logic [MemWidth-1:0]     rd_data_q;

  logic                    acc_fire;
  logic                    rd_fire;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [MemWidth-1:0]     mem_wdata;
  logic [ADDR_WIDTH-1:0]   mem_raddr;
  logic [MemWidth-1:0]     mem_rdata;
  logic [MemWidth-1:0]     fwd_data;
  logic [MemWidth-1:0]     acc_sum;
  logic [SumWidth-1:0]     ch_sum;

  assign acc_ready = (state_q == StRun) && !rd_req;
  assign acc_fire  = acc_valid && acc_ready;
  assign rd_fire   = rd_req && (state_q == StRun);
  assign init_busy = (state_q == StInit);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  // Reads and accepted accumulates never share a cycle, so one read port serves both.
  assign mem_raddr = rd_req ? rd_addr : acc_addr;

  // A pending write and a pending clear are mutually exclusive: a clear follows a
  // readout cycle, during which no accumulate can be accepted.
  assign mem_we    = !rst && ((state_q == StInit) || wr_pend_q || clr_pend_q);
  assign mem_waddr = (state_q == StInit) ? sweep_q :
                     clr_pend_q          ? clr_addr_q : wr_addr_q;
  assign mem_wdata = ((state_q == StRun) && wr_pend_q) ? wr_data_q : '0;

  always_comb begin
    fwd_data = mem_rdata;
    if (clr_pend_q && (clr_addr_q == mem_raddr)) begin
      fwd_data = '0;
    end
    if (wr_pend_q && (wr_addr_q == mem_raddr)) begin
      fwd_data = wr_data_q;
    end
  end

  always_comb begin
    acc_sum = '0;
    ch_sum  = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      ch_sum = SumWidth'(fwd_data[c*DATA_WIDTH +: DATA_WIDTH]) +
               SumWidth'(acc_pix[c*PIX_WIDTH +: PIX_WIDTH]);
      acc_sum[c*DATA_WIDTH +: DATA_WIDTH] =
          ch_sum[SumWidth-1] ? {DATA_WIDTH{1'b1}} : ch_sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      sweep_q    <= '0;
      wr_pend_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_pend_q  <= acc_fire;
      clr_pend_q <= rd_fire && rd_clear;
      rd_valid_q <= rd_fire;
      if (acc_fire) begin
        wr_addr_q <= acc_addr;
        wr_data_q <= acc_sum;
      end
      if (rd_fire) begin
        clr_addr_q <= rd_addr;
        rd_data_q  <= fwd_data;
      end
      unique case (state_q)
        StInit: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == '1) begin
            state_q <= StRun;
          end
        end
        StRun: ;
        default: state_q <= StInit;
      endcase
    end
  end

  zone_accum_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (MemWidth)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule
